// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for CPU pipeline stages.
//   skid_state_e : occupancy of a 2-entry skid buffer (EMPTY / ONE / FULL)
//   sel_width()  : select-index width for an N-input selector (minimum 1)
package cpu_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n1.sv
// Combinational NUM_IN:1 word select.
// Ports:
//   i_data : packed inputs, input i at [i*WIDTH +: WIDTH]
//   i_sel  : index of the input to select
//   o_data : selected word, 0 when i_sel is out of range
//   o_err  : 1 when i_sel >= NUM_IN
module mux_n1
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] i_data,
  input  logic [SEL_W-1:0]        i_sel,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_err
);

  always_comb begin
    o_data = '0;
    o_err  = 1'b1;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (i_sel == SEL_W'(i)) begin
        o_data = i_data[i*WIDTH +: WIDTH];
        o_err  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mux_skid_reg.sv
// Registered N:1 operand-select stage with a 2-entry skid buffer.
// The selected {data, err} beat is captured into "main" (head) or "skid"
// (second slot) with valid/ready handshakes on both sides.
// Ports:
//   clk, rst   : rising-edge clock, asynchronous active-high reset
//   in_data    : NUM_IN packed WIDTH-bit inputs
//   in_sel     : input index to capture
//   in_valid   : upstream beat present
//   in_ready   : registered; low only when both slots are full
//   flush      : synchronous discard of all held beats (beats any accept)
//   out_data   : head word
//   out_err    : head beat had an out-of-range select
//   out_valid  : head beat valid
//   out_ready  : downstream accepts head beat
// NUM_IN must be >= 2.
module mux_skid_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  skid_state_e      r_state;
  skid_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_main_data;
  logic             r_main_err;
  logic [WIDTH-1:0] r_skid_data;
  logic             r_skid_err;
  logic             r_in_ready;

  logic [WIDTH-1:0] w_sel_data;
  logic             w_sel_err;
  logic             w_accept;
  logic             w_pop;
  logic             w_load_main;
  logic             w_load_skid;
  logic             w_skid_to_main;

  mux_n1 #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_mux (
    .i_data (in_data),
    .i_sel  (in_sel),
    .o_data (w_sel_data),
    .o_err  (w_sel_err)
  );

  assign w_accept = in_valid & r_in_ready;
  assign w_pop    = out_valid & out_ready;

  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ONE;
            w_load_main = 1'b1;
          end
        end
        ONE: begin
          if (w_accept && w_pop) begin
            w_load_main = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = FULL;
            w_load_skid = 1'b1;
          end else if (w_pop) begin
            w_state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so a pop is the only possible event
          if (w_pop) begin
            w_state_nxt    = ONE;
            w_skid_to_main = 1'b1;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      // registered copy of "not FULL" so in_ready never depends on out_ready
      r_in_ready <= (w_state_nxt != FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_data <= '0;
      r_main_err  <= 1'b0;
      r_skid_data <= '0;
      r_skid_err  <= 1'b0;
    end else begin
      if (w_load_main) begin
        r_main_data <= w_sel_data;
        r_main_err  <= w_sel_err;
      end else if (w_skid_to_main) begin
        r_main_data <= r_skid_data;
        r_main_err  <= r_skid_err;
      end
      if (w_load_skid) begin
        r_skid_data <= w_sel_data;
        r_skid_err  <= w_sel_err;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main_data;
  assign out_err   = r_main_err;

endmodule

// File: tb/tb_mux_skid_reg.sv
// Bench for mux_skid_reg: DUT A (NUM_IN=4) and DUT B (NUM_IN=3, exercises
// the out-of-range select). Directed vector table, hand-written reset and
// out-of-range sequences, then random stress against a queue model.
module tb_mux_skid_reg;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [4*W-1:0] a_in_data;
  logic [1:0]     a_in_sel;
  logic           a_in_valid, a_in_ready, a_flush;
  logic [W-1:0]   a_out_data;
  logic           a_out_err, a_out_valid, a_out_ready;

  logic [3*W-1:0] b_in_data;
  logic [1:0]     b_in_sel;
  logic           b_in_valid, b_in_ready, b_flush;
  logic [W-1:0]   b_out_data;
  logic           b_out_err, b_out_valid, b_out_ready;

  mux_skid_reg #(.WIDTH(W), .NUM_IN(4)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_sel(a_in_sel),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .flush(a_flush),
    .out_data(a_out_data), .out_err(a_out_err), .out_valid(a_out_valid),
    .out_ready(a_out_ready)
  );

  mux_skid_reg #(.WIDTH(W), .NUM_IN(3)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_sel(b_in_sel),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .flush(b_flush),
    .out_data(b_out_data), .out_err(b_out_err), .out_valid(b_out_valid),
    .out_ready(b_out_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       valid;
    logic [1:0] sel;
    logic       ordy;
    logic       fl;
    logic       exp_valid;
    logic [31:0] exp_data;
    logic       exp_ready;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    logic        e;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  logic [31:0] wa[4];
  logic [31:0] wb[3];

  initial begin
    vec_t tbl[17];
    beat_t bt;
    bit acc_a, pop_a, acc_b, pop_b, fl_a, fl_b;

    a_in_valid = 0; a_in_sel = 0; a_flush = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_sel = 0; b_flush = 0; b_out_ready = 0;
    wa[0] = 32'h11111111; wa[1] = 32'h22222222; wa[2] = 32'h33333333; wa[3] = 32'h44444444;
    wb[0] = 32'hAAAAAAAA; wb[1] = 32'hBBBBBBBB; wb[2] = 32'hCCCCCCCC;
    for (int i = 0; i < 4; i++) a_in_data[i*W +: W] = wa[i];
    for (int i = 0; i < 3; i++) b_in_data[i*W +: W] = wb[i];

    //          valid sel  ordy fl   exp_v exp_data      exp_rdy
    tbl[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 32'h11111111, 1'b1};
    tbl[1]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 32'h22222222, 1'b1};
    tbl[2]  = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 32'h33333333, 1'b1};
    tbl[3]  = '{1'b1, 2'd3, 1'b1, 1'b0, 1'b1, 32'h44444444, 1'b1};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[5]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 32'h44444444, 1'b1};
    tbl[6]  = '{1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 32'h44444444, 1'b0};
    tbl[7]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 32'h44444444, 1'b0};
    tbl[8]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 32'h33333333, 1'b1};
    tbl[9]  = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 32'h22222222, 1'b1};
    tbl[10] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1};
    tbl[11] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b1};
    tbl[12] = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 32'h11111111, 1'b0};
    tbl[13] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1};
    tbl[14] = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 32'h44444444, 1'b1};
    tbl[15] = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1};
    tbl[16] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1};

    // Reset state
    step(); step();
    chk("rst_valid", 64'(a_out_valid), 64'd0);
    chk("rst_data",  64'(a_out_data),  64'd0);
    chk("rst_err",   64'(a_out_err),   64'd0);
    chk("rst_ready", 64'(a_in_ready),  64'd1);
    rst = 0;
    step();

    // Directed vector table on DUT A
    foreach (tbl[i]) begin
      a_in_valid = tbl[i].valid; a_in_sel = tbl[i].sel;
      a_out_ready = tbl[i].ordy; a_flush = tbl[i].fl;
      step();
      chk($sformatf("vec%0d_valid", i), 64'(a_out_valid), 64'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_ready", i), 64'(a_in_ready),  64'(tbl[i].exp_ready));
      if (tbl[i].exp_valid) begin
        chk($sformatf("vec%0d_data", i), 64'(a_out_data), 64'(tbl[i].exp_data));
        chk($sformatf("vec%0d_err", i),  64'(a_out_err),  64'd0);
      end
    end
    a_in_valid = 0; a_flush = 0;

    // Out-of-range select on DUT B
    b_out_ready = 1; b_in_valid = 1; b_in_sel = 2'd3;
    step();
    chk("oor_valid", 64'(b_out_valid), 64'd1);
    chk("oor_data",  64'(b_out_data),  64'd0);
    chk("oor_err",   64'(b_out_err),   64'd1);
    b_in_sel = 2'd1;
    step();
    chk("oor_next_data", 64'(b_out_data), 64'hBBBBBBBB);
    chk("oor_next_err",  64'(b_out_err),  64'd0);
    b_in_valid = 0;
    step();
    chk("oor_drain_valid", 64'(b_out_valid), 64'd0);

    // Asynchronous reset while a beat is held
    a_in_valid = 1; a_in_sel = 2'd2; a_out_ready = 0;
    step();
    a_in_valid = 0;
    chk("pre_rst_valid", 64'(a_out_valid), 64'd1);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", 64'(a_out_valid), 64'd0);
    chk("async_rst_data",  64'(a_out_data),  64'd0);
    chk("async_rst_err",   64'(a_out_err),   64'd0);
    chk("async_rst_ready", 64'(a_in_ready),  64'd1);
    step();
    rst = 0;
    step(); step();
    chk("post_rst_idle", 64'(a_out_valid), 64'd0);
    a_in_valid = 1; a_in_sel = 2'd1;
    step();
    a_in_valid = 0;
    chk("post_rst_first_data", 64'(a_out_data), 64'h22222222);
    a_out_ready = 1;
    step();
    chk("post_rst_drained", 64'(a_out_valid), 64'd0);

    // Random stress against queue models
    qa.delete(); qb.delete();
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < 4; i++) begin wa[i] = $urandom; a_in_data[i*W +: W] = wa[i]; end
      for (int i = 0; i < 3; i++) begin wb[i] = $urandom; b_in_data[i*W +: W] = wb[i]; end
      a_in_valid = 1'($urandom_range(0, 1)); a_in_sel = 2'($urandom_range(0, 3));
      b_in_valid = 1'($urandom_range(0, 1)); b_in_sel = 2'($urandom_range(0, 3));
      a_out_ready = ($urandom_range(0, 3) != 0); b_out_ready = 1'($urandom_range(0, 1));
      a_flush = ($urandom_range(0, 40) == 0); b_flush = ($urandom_range(0, 40) == 0);
      fl_a = a_flush; fl_b = b_flush;
      acc_a = a_in_valid && (qa.size() < 2);
      pop_a = a_out_ready && (qa.size() > 0);
      acc_b = b_in_valid && (qb.size() < 2);
      pop_b = b_out_ready && (qb.size() > 0);
      step();
      if (fl_a) qa.delete();
      else begin
        if (pop_a) void'(qa.pop_front());
        if (acc_a) begin bt.d = wa[a_in_sel]; bt.e = 1'b0; qa.push_back(bt); end
      end
      if (fl_b) qb.delete();
      else begin
        if (pop_b) void'(qb.pop_front());
        if (acc_b) begin
          if (b_in_sel < 3) begin bt.d = wb[b_in_sel]; bt.e = 1'b0; end
          else begin bt.d = '0; bt.e = 1'b1; end
          qb.push_back(bt);
        end
      end
      chk("rnd_a_valid", 64'(a_out_valid), 64'(qa.size() > 0));
      chk("rnd_a_ready", 64'(a_in_ready),  64'(qa.size() < 2));
      if (qa.size() > 0) begin
        chk("rnd_a_data", 64'(a_out_data), 64'(qa[0].d));
        chk("rnd_a_err",  64'(a_out_err),  64'(qa[0].e));
      end
      chk("rnd_b_valid", 64'(b_out_valid), 64'(qb.size() > 0));
      chk("rnd_b_ready", 64'(b_in_ready),  64'(qb.size() < 2));
      if (qb.size() > 0) begin
        chk("rnd_b_data", 64'(b_out_data), 64'(qb[0].d));
        chk("rnd_b_err",  64'(b_out_err),  64'(qb[0].e));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
